// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl
// Purpose  : Multi-cycle WIDTH-bit add/subtract built around one shared 4-bit
//            carry-lookahead slice, one nibble per clock, LSB nibble first.
//            Owns the operand shift registers, the inter-nibble carry, the
//            IDLE/RUN/DONE sequencer and the start/busy/done handshake.
// Ports    : clk, reset (sync, active-high)
//            start, sub, a[WIDTH-1:0], b[WIDTH-1:0]   request + operands
//            busy, done                               handshake status
//            sum[WIDTH-1:0], cout, ovf, zero          result and flags
// Options  : NSA_EARLY_EXIT_EN - finish as soon as the remaining operand
//            nibbles are zero and no carry is pending (variable latency).
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 32  // multiple of 4, at least 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic             c;
  logic [KW-1:0]    k;

  // ---------------------------------------------------------------------------
  // Shared 4-bit carry-lookahead slice on the low nibble of the operand regs
  // ---------------------------------------------------------------------------
  logic [3:0] g;
  logic [3:0] p;
  logic       c1, c2, c3, c4;
  logic [3:0] nib;

  assign g  = areg[3:0] & breg[3:0];
  assign p  = areg[3:0] ^ breg[3:0];
  assign c1 = g[0] | (p[0] & c);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c);
  assign nib = p ^ {c3, c2, c1, c};

  logic [WIDTH-1:0] areg_sh;
  logic [WIDTH-1:0] breg_sh;
  logic [WIDTH-1:0] sum_nxt;

  assign areg_sh = areg >> 4;
  assign breg_sh = breg >> 4;

  // Result with the current nibble merged in; also feeds the zero flag so it
  // reflects the final sum in the same edge that enters DONE.
  always_comb begin
    sum_nxt = sum;
    sum_nxt[{k, 2'b00} +: 4] = nib;
  end

  logic last;
  logic early;
  logic finish;

  assign last = (k == KW'(NIB - 1));

`ifdef NSA_EARLY_EXIT_EN
  // Nothing left to add and no carry to propagate: the upper sum nibbles are
  // already zero from the start-time clear.
  assign early = (areg_sh == '0) && (breg_sh == '0) && !c4;
`else
  assign early = 1'b0;
`endif

  assign finish = last | early;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (finish) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs (decoded from the state register only)
  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      areg <= '0;
      breg <= '0;
      c    <= 1'b0;
      k    <= '0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            // Subtract as A + ~B + 1: the +1 enters as the initial carry.
            areg <= a;
            breg <= sub ? ~b : b;
            c    <= sub;
            k    <= '0;
            sum  <= '0;
          end
        end
        S_RUN: begin
          sum  <= sum_nxt;
          areg <= areg_sh;
          breg <= breg_sh;
          c    <= c4;
          k    <= k + 1'b1;
          if (finish) begin
            // Final nibble takes the real MSB flags; an early exit leaves no
            // MSB activity, so carry and overflow are both zero.
            if (last) begin
              cout <= c4;
              ovf  <= c3 ^ c4;
            end else begin
              cout <= 1'b0;
              ovf  <= 1'b0;
            end
            zero <= (sum_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder_ctrl
// Purpose  : Self-checking bench for nibble_serial_adder_ctrl (WIDTH=32).
//            Directed corner cases plus random operations against an
//            arithmetic reference model; covers handshake, back-to-back
//            starts, ignored mid-run starts and reset abort.
//            Honours NSA_EARLY_EXIT_EN for expected latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 32;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .zero  (zero)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Expected cycles from start edge to done, from the arithmetic meaning of the
  // early-exit rule: the first nibble count n after which both remaining
  // operands are zero and the low 4n-bit addition produced no carry.
  function automatic int exp_latency(input logic [31:0] ea, input logic [31:0] eb, input logic es);
`ifdef NSA_EARLY_EXIT_EN
    logic [63:0] bb;
    logic [63:0] lo;
    logic [63:0] part;
    bb = {32'd0, (es ? ~eb : eb)};
    for (int n = 1; n < NIB; n++) begin
      lo   = (64'd1 << (4 * n)) - 64'd1;
      part = ({32'd0, ea} & lo) + (bb & lo) + {63'd0, es};
      if ((({32'd0, ea} >> (4 * n)) == 64'd0) && ((bb >> (4 * n)) == 64'd0) &&
          (((part >> (4 * n)) & 64'd1) == 64'd0))
        return n;
    end
    return NIB;
`else
    return NIB;
`endif
  endfunction

  // Called #1 after a rising edge with the DUT in IDLE or DONE. Returns #1
  // after the edge on which done was observed (DUT in DONE), or after timeout.
  task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic os,
                        input bit mid_start, input string tag);
    logic [32:0] full;
    logic [31:0] es;
    logic        ec, eo, ez;
    int          lat;
    int          cnt;
    bit          seen;
    if (os) full = {1'b0, oa} + {1'b0, ~ob} + 33'd1;
    else    full = {1'b0, oa} + {1'b0, ob};
    es  = full[31:0];
    ec  = full[32];
    eo  = os ? ((oa[31] != ob[31]) && (es[31] != oa[31]))
             : ((oa[31] == ob[31]) && (es[31] != oa[31]));
    ez  = (es == 32'd0);
    lat = exp_latency(oa, ob, os);

    start = 1'b1; a = oa; b = ob; sub = os;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; sub = 1'($urandom);   // must not be sampled now
    check_val({tag, "_busy_e0"}, {63'd0, busy}, 64'd1);

    seen = 0;
    cnt  = 0;
    for (int i = 1; i <= NIB + 3; i++) begin
      if (mid_start && i == 3) begin
        start = 1'b1; a = $urandom; b = $urandom; sub = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        seen = 1; cnt = i;
        break;
      end
    end
    start = 1'b0;
    if (!seen) cnt = NIB + 4;
    check_val({tag, "_latency"}, 64'(cnt), 64'(lat));
    check_val({tag, "_sum"},  {32'd0, sum}, {32'd0, es});
    check_val({tag, "_flags"}, {61'd0, cout, ovf, zero}, {61'd0, ec, eo, ez});
    check_val({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
  endtask

  // One cycle after a done with no new start: back to IDLE, result held.
  task automatic idle_after(input logic [31:0] held, input string tag);
    @(posedge clk); #1;
    check_val({tag, "_pulse"}, {62'd0, busy, done}, 64'd0);
    check_val({tag, "_held"}, {32'd0, sum}, {32'd0, held});
  endtask

  initial begin
    logic [31:0] ra, rb, prev;
    logic        rs;
    bit          seen;
    int          gap;

    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_val("reset_state", {28'd0, sum, busy, done, cout, ovf, zero}, 64'd0);

    // Directed corner cases
    run_op(32'h0000_000F, 32'h0000_0001, 1'b0, 0, "carry_nib");   idle_after(32'h0000_0010, "c1");
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 0, "sub_neg");     idle_after(32'hFFFF_FFFE, "c2");
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0, "sub_ovf");     idle_after(32'h7FFF_FFFF, "c3");
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, "add_ovf");     idle_after(32'h8000_0000, "c4");
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, "add_wrap");    idle_after(32'h0000_0000, "c5");
    run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 0, "add_small");   idle_after(32'h0000_0003, "c6");
    run_op(32'h1000_0000, 32'h0000_0000, 1'b0, 0, "add_top");     idle_after(32'h1000_0000, "c7");

    // Start pulsed mid-run is ignored and not queued
    run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1, "mid_start");   idle_after(32'h2222_2221, "mid");

    // Back-to-back: start in the DONE cycle
    run_op(32'hDEAD_BEEF, 32'h0000_1111, 1'b0, 0, "b2b_a");
    run_op(32'h0000_0010, 32'h0000_0020, 1'b1, 0, "b2b_b");
    idle_after(32'hFFFF_FFF0, "b2b");

    // Random operations, some with small operands, mixed gaps
    for (int t = 0; t < 40; t++) begin
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 31);
      rs = 1'($urandom);
      if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;   // ~B small in subtract
      run_op(ra, rb, rs, 0, "rnd");
      prev = rs ? (ra - rb) : (ra + rb);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle_after(prev, "rnd_gap");
      if (gap > 1) @(posedge clk);
      #0;
    end

    // Reset in cycle 4 of RUN aborts with no done pulse
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, "pre_abort");
    idle_after(32'h0000_0000, "pre_abort");
    start = 1'b1; a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("abort_outputs", {28'd0, sum, busy, done, cout, ovf, zero}, 64'd0);
    seen = 0;
    for (int i = 0; i < NIB + 3; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    check_val("abort_no_done", {63'd0, seen}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
